// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-port round-robin arbiter in front of a single-port RAM
module mem_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int NPORTS     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS-1:0]            req,
  input  logic [NPORTS-1:0]            we,
  input  logic [NPORTS*WORD_WIDTH-1:0] addr,
  input  logic [NPORTS*WORD_WIDTH-1:0] wdata,
  output logic [NPORTS-1:0]            ack,
  output logic [WORD_WIDTH-1:0]        rdata,
  output logic [NPORTS-1:0]            grant,
  output logic                         busy,
  output logic [WORD_WIDTH-1:0]        mem_addr,
  output logic [WORD_WIDTH-1:0]        mem_wdata,
  output logic                         mem_we,
  input  logic [WORD_WIDTH-1:0]        mem_rdata
);

  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPORTS - 1);
  localparam logic [NPORTS-1:0] ONE_HOT0 = {{(NPORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, CAPTURE, ACK} state_t;

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        last_grant, last_grant_nx;
  logic [IDX_W-1:0]        win, win_nx;
  logic                    lat_we, lat_we_nx;
  logic [NPORTS-1:0]       ack_nx, grant_nx;
  logic                    busy_nx, mem_we_nx;
  logic [WORD_WIDTH-1:0]   rdata_nx, mem_addr_nx, mem_wdata_nx;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick, cand;

  // Walk the ports cyclically starting just after last_grant; first requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = last_grant;
    cand       = last_grant;
    for (int k = 0; k < NPORTS; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    win_nx        = win;
    lat_we_nx     = lat_we;
    ack_nx        = '0;
    grant_nx      = grant;
    busy_nx       = busy;
    mem_we_nx     = 1'b0;
    rdata_nx      = rdata;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    case (state)
      IDLE: begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        if (pick_valid) begin
          // mem_addr/mem_wdata double as the request latch: they hold until the next grant.
          state_nx     = BUSY;
          win_nx       = pick;
          lat_we_nx    = we[pick];
          mem_we_nx    = we[pick];
          mem_addr_nx  = addr[WORD_WIDTH*pick +: WORD_WIDTH];
          mem_wdata_nx = wdata[WORD_WIDTH*pick +: WORD_WIDTH];
          grant_nx     = ONE_HOT0 << pick;
          busy_nx      = 1'b1;
        end
      end
      BUSY: begin
        state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (!lat_we) rdata_nx = mem_rdata;
        ack_nx   = grant;
        state_nx = ACK;
      end
      ACK: begin
        last_grant_nx = win;
        grant_nx      = '0;
        busy_nx       = 1'b0;
        state_nx      = IDLE;
      end
      default: begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= LAST_IDX;
      win        <= '0;
      lat_we     <= 1'b0;
      ack        <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      win        <= win_nx;
      lat_we     <= lat_we_nx;
      ack        <= ack_nx;
      grant      <= grant_nx;
      busy       <= busy_nx;
      mem_we     <= mem_we_nx;
      rdata      <= rdata_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int W = 16;
  localparam int N = 3;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req, we;
  logic [N*W-1:0] addr, wdata;
  logic [N-1:0]   ack, grant;
  logic [W-1:0]   rdata, mem_addr, mem_wdata, mem_rdata;
  logic           busy, mem_we;
  logic [W-1:0]   ram [0:65535];
  logic           wrote_0020;
  int             n_pass = 0;
  int             n_total = 0;

  mem_arbiter #(.WORD_WIDTH(W), .NPORTS(N)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (!rst) wrote_0020 <= 1'b0;
    else if (mem_we && mem_addr == 16'h0020) wrote_0020 <= 1'b1;
  end

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [W-1:0] a, input logic [W-1:0] d);
    req[p] = r;
    we[p] = w;
    addr[W*p +: W] = a;
    wdata[W*p +: W] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output logic [N-1:0] seen, output int cyc);
    seen = '0;
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        seen = ack;
        cyc = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    n_total++; if (ack !== 3'b000) $display("FAIL reset_ack: got %b expected 000", ack); else n_pass++;
    n_total++; if (grant !== 3'b000) $display("FAIL reset_grant: got %b expected 000", grant); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 16'h0000) $display("FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); else n_pass++;
    n_total++; if (rdata !== 16'h0000) $display("FAIL reset_rdata: got %h expected 0000", rdata); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    logic [N-1:0] seen;
    int cyc;
    set_port(0, 1'b1, 1'b1, 16'h0010, 16'h1234);
    @(negedge clk);
    n_total++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we_busy: got %b expected 1", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 16'h0010) $display("FAIL wr_mem_addr: got %h expected 0010", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 16'h1234) $display("FAIL wr_mem_wdata: got %h expected 1234", mem_wdata); else n_pass++;
    n_total++; if (grant !== 3'b001) $display("FAIL wr_grant: got %b expected 001", grant); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b expected 1", busy); else n_pass++;
    @(negedge clk);
    n_total++; if (mem_we !== 1'b0) $display("FAIL wr_mem_we_capture: got %b expected 0", mem_we); else n_pass++;
    n_total++; if (ack !== 3'b000) $display("FAIL wr_ack_early: got %b expected 000", ack); else n_pass++;
    @(negedge clk);
    n_total++; if (ack !== 3'b001) $display("FAIL wr_ack: got %b expected 001", ack); else n_pass++;
    set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    wait_ack(10, seen, cyc);
    n_total++; if (seen !== 3'b001) $display("FAIL rd_ack: got %b expected 001", seen); else n_pass++;
    n_total++; if (cyc !== 4) $display("FAIL rd_latency: got %0d expected 4", cyc); else n_pass++;
    n_total++; if (rdata !== 16'h1234) $display("FAIL rd_rdata: got %h expected 1234", rdata); else n_pass++;
    n_total++; if (ram[16'h0010] !== 16'h1234) $display("FAIL wr_ram: got %h expected 1234", ram[16'h0010]); else n_pass++;
    set_port(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rd_idle_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rr_exp [6];
    logic [N-1:0] seen;
    int cyc;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    set_port(1, 1'b1, 1'b0, 16'h0011, 16'h0000);
    set_port(2, 1'b1, 1'b0, 16'h0012, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      wait_ack(12, seen, cyc);
      n_total++; if (seen !== rr_exp[i]) $display("FAIL rr_order_%0d: got %b expected %b", i, seen, rr_exp[i]); else n_pass++;
      n_total++; if (cyc !== ((i == 0) ? 3 : 4)) $display("FAIL rr_spacing_%0d: got %0d expected %0d", i, cyc, (i == 0) ? 3 : 4); else n_pass++;
      n_total++; if (grant !== rr_exp[i]) $display("FAIL rr_grant_%0d: got %b expected %b", i, grant, rr_exp[i]); else n_pass++;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] seen;
    int cyc;
    set_port(2, 1'b1, 1'b1, 16'h0300, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      wait_ack(10, seen, cyc);
      n_total++; if (seen !== 3'b100) $display("FAIL b2b_ack_%0d: got %b expected 100", i, seen); else n_pass++;
      n_total++; if (cyc !== 3) $display("FAIL b2b_latency_%0d: got %0d expected 3", i, cyc); else n_pass++;
      if (i == 2) req[2] = 1'b0;
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL b2b_gap_busy_%0d: got %b expected 0", i, busy); else n_pass++;
    end
    n_total++; if (ram[16'h0300] !== 16'hBEEF) $display("FAIL b2b_ram: got %h expected beef", ram[16'h0300]); else n_pass++;
  endtask

  task automatic test_drop_mid();
    logic [N-1:0] seen;
    int cyc;
    set_port(1, 1'b1, 1'b1, 16'h0040, 16'h5A5A);
    @(negedge clk);
    n_total++; if (mem_addr !== 16'h0040) $display("FAIL drop_mem_addr: got %h expected 0040", mem_addr); else n_pass++;
    set_port(1, 1'b0, 1'b1, 16'h0020, 16'hFFFF);
    wait_ack(8, seen, cyc);
    n_total++; if (seen !== 3'b010) $display("FAIL drop_ack: got %b expected 010", seen); else n_pass++;
    n_total++; if (cyc !== 2) $display("FAIL drop_latency: got %0d expected 2", cyc); else n_pass++;
    n_total++; if (ram[16'h0040] !== 16'h5A5A) $display("FAIL drop_ram: got %h expected 5a5a", ram[16'h0040]); else n_pass++;
    n_total++; if (wrote_0020 !== 1'b0) $display("FAIL drop_stray_write: got %b expected 0", wrote_0020); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] seen;
    int cyc;
    set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    repeat (2) @(negedge clk);
    n_total++; if (grant !== 3'b001) $display("FAIL rstmid_grant_capture: got %b expected 001", grant); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (ack !== 3'b000) $display("FAIL rstmid_ack: got %b expected 000", ack); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (grant !== 3'b000) $display("FAIL rstmid_grant: got %b expected 000", grant); else n_pass++;
    n_total++; if (rdata !== 16'h0000) $display("FAIL rstmid_rdata: got %h expected 0000", rdata); else n_pass++;
    n_total++; if (mem_addr !== 16'h0000) $display("FAIL rstmid_mem_addr: got %h expected 0000", mem_addr); else n_pass++;
    set_port(1, 1'b1, 1'b0, 16'h0011, 16'h0000);
    set_port(2, 1'b1, 1'b0, 16'h0012, 16'h0000);
    rst = 1'b1;
    wait_ack(8, seen, cyc);
    n_total++; if (seen !== 3'b001) $display("FAIL rstmid_first_winner: got %b expected 001", seen); else n_pass++;
    n_total++; if (cyc !== 3) $display("FAIL rstmid_latency: got %0d expected 3", cyc); else n_pass++;
    req = '0;
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 16'h0050, 16'h7777);
    @(negedge clk);
    n_total++; if (mem_we !== 1'b1) $display("FAIL rstwr_mem_we_busy: got %b expected 1", mem_we); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (mem_we !== 1'b0) $display("FAIL rstwr_mem_we_after: got %b expected 0", mem_we); else n_pass++;
    req = '0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_debug_vs_cpu();
    logic [N-1:0] seen;
    int cyc;
    int debug_at;
    set_port(2, 1'b1, 1'b1, 16'hF7FF, 16'hA5C3);
    wait_ack(8, seen, cyc);
    n_total++; if (seen !== 3'b100) $display("FAIL dbg_preload_ack: got %b expected 100", seen); else n_pass++;
    req = '0;
    @(negedge clk);
    debug_at = 0;
    set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    set_port(2, 1'b1, 1'b0, 16'hF7FF, 16'h0000);
    for (int t = 1; t <= 3; t++) begin
      wait_ack(12, seen, cyc);
      n_total++; if ($countones(seen) !== 1) $display("FAIL dbg_onehot_%0d: got %b expected one bit", t, seen); else n_pass++;
      if (seen === 3'b100) begin
        debug_at = t;
        n_total++; if (rdata !== 16'hA5C3) $display("FAIL dbg_rdata: got %h expected a5c3", rdata); else n_pass++;
        req[2] = 1'b0;
      end
    end
    n_total++; if (debug_at !== 2) $display("FAIL dbg_service_slot: got %0d expected 2", debug_at); else n_pass++;
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_drop_mid();
    test_reset_mid();
    test_debug_vs_cpu();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
